// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory, stalling on the memory ready handshake.
module multicycle_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic       zero_i,
  input  logic       neg_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] pc_src_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EXE  = 4'd2,
    S_MADR = 4'd3,
    S_MRD  = 4'd4,
    S_MWB  = 4'd5,
    S_MWR  = 4'd6,
    S_AWB  = 4'd7,
    S_BR   = 4'd8,
    S_JMP  = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BLEZ  = 6'd6;
  localparam logic [5:0] OP_BGTZ  = 6'd7;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  state_t      state_r;
  state_t      state_next_s;
  logic        pc_write_s;
  logic        ir_write_s;
  logic        iord_s;
  logic        mem_read_s;
  logic        mem_write_s;
  logic        reg_write_s;
  logic        reg_dst_s;
  logic        mem_to_reg_s;
  logic        alu_src_a_s;
  logic [1:0]  alu_src_b_s;
  logic [2:0]  alu_op_s;
  logic [1:0]  pc_src_s;
  logic        instr_done_s;
  logic        illegal_s;

  // blez/bgtz rely on rt=$0, so the ALU compare result reflects rs alone
  function automatic logic branch_taken(input logic [5:0] op, input logic zero,
                                        input logic neg);
    logic take;
    case (op)
      OP_BEQ:  take = zero;
      OP_BNE:  take = ~zero;
      OP_BLEZ: take = zero | neg;
      OP_BGTZ: take = ~zero & ~neg;
      default: take = 1'b0;
    endcase
    return take;
  endfunction

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= S_IF;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_next_s = S_IF;
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    iord_s       = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 3'b000;
    pc_src_s     = 2'b00;
    instr_done_s = 1'b0;
    illegal_s    = 1'b0;
    case (state_r)
      S_IF: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'b01;
        alu_op_s    = 3'b001;
        if (mem_ready_i) begin
          ir_write_s   = 1'b1;
          pc_write_s   = 1'b1;
          state_next_s = S_ID;
        end else begin
          state_next_s = S_IF;
        end
      end
      S_ID: begin
        alu_src_b_s = 2'b11;
        alu_op_s    = 3'b001;
        case (instr_op_i)
          OP_RTYPE, OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI: state_next_s = S_EXE;
          OP_LW, OP_SW:                                state_next_s = S_MADR;
          OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:            state_next_s = S_BR;
          OP_J:                                        state_next_s = S_JMP;
          default: begin
            illegal_s    = 1'b1;
            state_next_s = S_IF;
          end
        endcase
      end
      S_EXE: begin
        alu_src_a_s  = 1'b1;
        state_next_s = S_AWB;
        case (instr_op_i)
          OP_RTYPE: begin
            alu_src_b_s = 2'b00;
            alu_op_s    = 3'b000;
          end
          OP_ADDI: begin
            alu_src_b_s = 2'b10;
            alu_op_s    = 3'b001;
          end
          OP_SLTIU: begin
            alu_src_b_s = 2'b10;
            alu_op_s    = 3'b010;
          end
          OP_LUI: begin
            alu_src_b_s = 2'b10;
            alu_op_s    = 3'b011;
          end
          OP_ORI: begin
            alu_src_b_s = 2'b10;
            alu_op_s    = 3'b111;
          end
          default: begin
            alu_src_b_s = 2'b10;
            alu_op_s    = 3'b000;
          end
        endcase
      end
      S_AWB: begin
        reg_write_s  = 1'b1;
        reg_dst_s    = (instr_op_i == OP_RTYPE);
        instr_done_s = 1'b1;
        state_next_s = S_IF;
      end
      S_MADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        alu_op_s    = 3'b101;
        case (instr_op_i)
          OP_LW:   state_next_s = S_MRD;
          OP_SW:   state_next_s = S_MWR;
          default: state_next_s = S_IF;
        endcase
      end
      S_MRD: begin
        mem_read_s = 1'b1;
        iord_s     = 1'b1;
        if (mem_ready_i) begin
          state_next_s = S_MWB;
        end else begin
          state_next_s = S_MRD;
        end
      end
      S_MWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        instr_done_s = 1'b1;
        state_next_s = S_IF;
      end
      S_MWR: begin
        mem_write_s = 1'b1;
        iord_s      = 1'b1;
        if (mem_ready_i) begin
          instr_done_s = 1'b1;
          state_next_s = S_IF;
        end else begin
          state_next_s = S_MWR;
        end
      end
      S_BR: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 3'b110;
        pc_src_s     = 2'b01;
        instr_done_s = 1'b1;
        pc_write_s   = branch_taken(instr_op_i, zero_i, neg_i);
        state_next_s = S_IF;
      end
      S_JMP: begin
        pc_write_s   = 1'b1;
        pc_src_s     = 2'b10;
        instr_done_s = 1'b1;
        state_next_s = S_IF;
      end
      default: state_next_s = S_IF;
    endcase
  end

  // Reset must silence every enable immediately, not only after the state flop clears
  assign pc_write_o   = pc_write_s   & ~rst_i;
  assign ir_write_o   = ir_write_s   & ~rst_i;
  assign iord_o       = iord_s       & ~rst_i;
  assign mem_read_o   = mem_read_s   & ~rst_i;
  assign mem_write_o  = mem_write_s  & ~rst_i;
  assign reg_write_o  = reg_write_s  & ~rst_i;
  assign reg_dst_o    = reg_dst_s    & ~rst_i;
  assign mem_to_reg_o = mem_to_reg_s & ~rst_i;
  assign alu_src_a_o  = alu_src_a_s  & ~rst_i;
  assign alu_src_b_o  = alu_src_b_s  & {2{~rst_i}};
  assign alu_op_o     = alu_op_s     & {3{~rst_i}};
  assign pc_src_o     = pc_src_s     & {2{~rst_i}};
  assign instr_done_o = instr_done_s & ~rst_i;
  assign illegal_o    = illegal_s    & ~rst_i;
  assign state_o      = state_r      & {4{~rst_i}};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed per-cycle vectors queue their
// expected outputs; a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       neg = 1'b0;
  logic       rdy = 1'b0;
  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, instr_done, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk_i(clk), .rst_i(rst), .instr_op_i(op), .zero_i(zero), .neg_i(neg),
    .mem_ready_i(rdy), .pc_write_o(pc_write), .ir_write_o(ir_write),
    .iord_o(iord), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .reg_write_o(reg_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
    .pc_src_o(pc_src), .instr_done_o(instr_done), .illegal_o(illegal),
    .state_o(state)
  );

  always #5 clk = ~clk;

  // Field order: pw ir iord mr mw rw rd m2r asa asb[2] aop[3] ps[2] done ill
  localparam logic [17:0] ZERO     = 18'b0_0_0_0_0_0_0_0_0_00_000_00_0_0;
  localparam logic [17:0] IF_WAIT  = 18'b0_0_0_1_0_0_0_0_0_01_001_00_0_0;
  localparam logic [17:0] IF_RDY   = 18'b1_1_0_1_0_0_0_0_0_01_001_00_0_0;
  localparam logic [17:0] ID       = 18'b0_0_0_0_0_0_0_0_0_11_001_00_0_0;
  localparam logic [17:0] ID_ILL   = 18'b0_0_0_0_0_0_0_0_0_11_001_00_0_1;
  localparam logic [17:0] EXE_ADDI = 18'b0_0_0_0_0_0_0_0_1_10_001_00_0_0;
  localparam logic [17:0] EXE_R    = 18'b0_0_0_0_0_0_0_0_1_00_000_00_0_0;
  localparam logic [17:0] EXE_ORI  = 18'b0_0_0_0_0_0_0_0_1_10_111_00_0_0;
  localparam logic [17:0] AWB_I    = 18'b0_0_0_0_0_1_0_0_0_00_000_00_1_0;
  localparam logic [17:0] AWB_R    = 18'b0_0_0_0_0_1_1_0_0_00_000_00_1_0;
  localparam logic [17:0] MADR     = 18'b0_0_0_0_0_0_0_0_1_10_101_00_0_0;
  localparam logic [17:0] MRD      = 18'b0_0_1_1_0_0_0_0_0_00_000_00_0_0;
  localparam logic [17:0] MWB      = 18'b0_0_0_0_0_1_0_1_0_00_000_00_1_0;
  localparam logic [17:0] MWR_WAIT = 18'b0_0_1_0_1_0_0_0_0_00_000_00_0_0;
  localparam logic [17:0] MWR_RDY  = 18'b0_0_1_0_1_0_0_0_0_00_000_00_1_0;
  localparam logic [17:0] BR_T     = 18'b1_0_0_0_0_0_0_0_1_00_110_01_1_0;
  localparam logic [17:0] BR_NT    = 18'b0_0_0_0_0_0_0_0_1_00_110_01_1_0;
  localparam logic [17:0] JMP      = 18'b1_0_0_0_0_0_0_0_0_00_000_10_1_0;

  logic [21:0] exp_q[$];
  int          tag_q[$];
  int          checks = 0;
  int          failures = 0;
  int          step_n = 0;
  logic [21:0] act;
  logic [21:0] mon_exp;
  int          mon_tag;

  assign act = {state, pc_write, ir_write, iord, mem_read, mem_write, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
                instr_done, illegal};

  // One clock cycle of stimulus plus the outputs required during that cycle
  task automatic step(input logic r, input logic [5:0] o, input logic m,
                      input logic z, input logic n, input logic [3:0] st,
                      input logic [17:0] ctl);
    @(posedge clk);
    #1;
    rst  = r;
    op   = o;
    rdy  = m;
    zero = z;
    neg  = n;
    exp_q.push_back({st, ctl});
    tag_q.push_back(step_n);
    step_n++;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        checks++;
        if (act !== mon_exp) begin
          failures++;
          $display("FAIL cyc_%0d state/ctl actual=%b required=%b", mon_tag, act, mon_exp);
        end
      end
    end
  end

  initial begin : stimulus
    // reset held from time 0
    step(1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 4'd0, ZERO);
    step(1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 4'd0, ZERO);
    // addi, zero wait
    step(1'b0, 6'd8, 1'b1, 1'b0, 1'b0, 4'd0, IF_RDY);
    step(1'b0, 6'd8, 1'b1, 1'b0, 1'b0, 4'd1, ID);
    step(1'b0, 6'd8, 1'b1, 1'b0, 1'b0, 4'd2, EXE_ADDI);
    step(1'b0, 6'd8, 1'b1, 1'b0, 1'b0, 4'd7, AWB_I);
    // R-type with ready low where it must be ignored
    step(1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 4'd0, IF_RDY);
    step(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 4'd1, ID);
    step(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 4'd2, EXE_R);
    step(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 4'd7, AWB_R);
    // ori
    step(1'b0, 6'd13, 1'b1, 1'b0, 1'b0, 4'd0, IF_RDY);
    step(1'b0, 6'd13, 1'b1, 1'b0, 1'b0, 4'd1, ID);
    step(1'b0, 6'd13, 1'b1, 1'b0, 1'b0, 4'd2, EXE_ORI);
    step(1'b0, 6'd13, 1'b1, 1'b0, 1'b0, 4'd7, AWB_I);
    // lw: 2 waits in IF, 3 in MRD -> 10 cycles
    step(1'b0, 6'd35, 1'b0, 1'b0, 1'b0, 4'd0, IF_WAIT);
    step(1'b0, 6'd35, 1'b0, 1'b0, 1'b0, 4'd0, IF_WAIT);
    step(1'b0, 6'd35, 1'b1, 1'b0, 1'b0, 4'd0, IF_RDY);
    step(1'b0, 6'd35, 1'b0, 1'b0, 1'b0, 4'd1, ID);
    step(1'b0, 6'd35, 1'b0, 1'b0, 1'b0, 4'd3, MADR);
    for (int i = 0; i < 3; i++) step(1'b0, 6'd35, 1'b0, 1'b0, 1'b0, 4'd4, MRD);
    step(1'b0, 6'd35, 1'b1, 1'b0, 1'b0, 4'd4, MRD);
    step(1'b0, 6'd35, 1'b0, 1'b0, 1'b0, 4'd5, MWB);
    // sw: ready low 4 cycles in MWR
    step(1'b0, 6'd43, 1'b1, 1'b0, 1'b0, 4'd0, IF_RDY);
    step(1'b0, 6'd43, 1'b1, 1'b0, 1'b0, 4'd1, ID);
    step(1'b0, 6'd43, 1'b1, 1'b0, 1'b0, 4'd3, MADR);
    for (int i = 0; i < 4; i++) step(1'b0, 6'd43, 1'b0, 1'b0, 1'b0, 4'd6, MWR_WAIT);
    step(1'b0, 6'd43, 1'b1, 1'b0, 1'b0, 4'd6, MWR_RDY);
    // beq taken
    step(1'b0, 6'd4, 1'b1, 1'b1, 1'b0, 4'd0, IF_RDY);
    step(1'b0, 6'd4, 1'b1, 1'b1, 1'b0, 4'd1, ID);
    step(1'b0, 6'd4, 1'b1, 1'b1, 1'b0, 4'd8, BR_T);
    // bgtz with negative operand: not taken
    step(1'b0, 6'd7, 1'b1, 1'b0, 1'b1, 4'd0, IF_RDY);
    step(1'b0, 6'd7, 1'b1, 1'b0, 1'b1, 4'd1, ID);
    step(1'b0, 6'd7, 1'b1, 1'b0, 1'b1, 4'd8, BR_NT);
    // bgtz with positive operand: taken
    step(1'b0, 6'd7, 1'b1, 1'b0, 1'b0, 4'd0, IF_RDY);
    step(1'b0, 6'd7, 1'b1, 1'b0, 1'b0, 4'd1, ID);
    step(1'b0, 6'd7, 1'b1, 1'b0, 1'b0, 4'd8, BR_T);
    // blez with zero: taken
    step(1'b0, 6'd6, 1'b1, 1'b1, 1'b0, 4'd0, IF_RDY);
    step(1'b0, 6'd6, 1'b1, 1'b1, 1'b0, 4'd1, ID);
    step(1'b0, 6'd6, 1'b1, 1'b1, 1'b0, 4'd8, BR_T);
    // bne with equal operands: not taken
    step(1'b0, 6'd5, 1'b1, 1'b1, 1'b0, 4'd0, IF_RDY);
    step(1'b0, 6'd5, 1'b1, 1'b1, 1'b0, 4'd1, ID);
    step(1'b0, 6'd5, 1'b1, 1'b1, 1'b0, 4'd8, BR_NT);
    // j
    step(1'b0, 6'd2, 1'b1, 1'b0, 1'b0, 4'd0, IF_RDY);
    step(1'b0, 6'd2, 1'b1, 1'b0, 1'b0, 4'd1, ID);
    step(1'b0, 6'd2, 1'b1, 1'b0, 1'b0, 4'd9, JMP);
    // illegal opcode 0x3F: pulse in ID, then straight back to IF
    step(1'b0, 6'h3F, 1'b1, 1'b0, 1'b0, 4'd0, IF_RDY);
    step(1'b0, 6'h3F, 1'b1, 1'b0, 1'b0, 4'd1, ID_ILL);
    step(1'b0, 6'h3F, 1'b0, 1'b0, 1'b0, 4'd0, IF_WAIT);
    // lw aborted by reset while waiting in MRD
    step(1'b0, 6'd35, 1'b1, 1'b0, 1'b0, 4'd0, IF_RDY);
    step(1'b0, 6'd35, 1'b1, 1'b0, 1'b0, 4'd1, ID);
    step(1'b0, 6'd35, 1'b0, 1'b0, 1'b0, 4'd3, MADR);
    step(1'b0, 6'd35, 1'b0, 1'b0, 1'b0, 4'd4, MRD);
    step(1'b1, 6'd35, 1'b1, 1'b0, 1'b0, 4'd0, ZERO);
    step(1'b1, 6'd35, 1'b1, 1'b0, 1'b0, 4'd0, ZERO);
    step(1'b0, 6'd35, 1'b0, 1'b0, 1'b0, 4'd0, IF_WAIT);
    step(1'b0, 6'd35, 1'b1, 1'b0, 1'b0, 4'd0, IF_RDY);
    step(1'b0, 6'd35, 1'b1, 1'b0, 1'b0, 4'd1, ID);
    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
